// File: rtl/rf_ctrl_pkg.sv
// rf_ctrl_pkg: shared widths and types for register-file writeback control
package rf_ctrl_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int REG_AW = 5;
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_0, GNT_1} grant_e;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: busy bits for destinations still owed a multi-cycle writeback
module rf_scoreboard #(
  parameter int NREG = rf_ctrl_pkg::NREG
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          set_en,
  input  logic [rf_ctrl_pkg::REG_AW-1:0] set_idx,
  input  logic                          clr_en,
  input  logic [rf_ctrl_pkg::REG_AW-1:0] clr_idx,
  output logic [NREG-1:0]               busy_vec,
  output logic                          claim_err
);
  logic [NREG-1:0] w_next;
  logic            w_err;
  always_comb begin
    w_next = busy_vec;
    if (clr_en) w_next[clr_idx] = 1'b0;
    if (set_en) w_next[set_idx] = 1'b1;
    w_next[0] = 1'b0;
    w_err = set_en && busy_vec[set_idx] && !(clr_en && clr_idx == set_idx);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_vec  <= '0;
      claim_err <= 1'b0;
    end else begin
      busy_vec  <= w_next;
      claim_err <= w_err;
    end
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port between ALU and mul/div writebacks
module rf_wb_arbiter #(
  parameter int XLEN     = rf_ctrl_pkg::XLEN,
  parameter int NREG     = rf_ctrl_pkg::NREG,
  parameter int MAX_WAIT = 4
) (
  input  logic                          cpu_clk,
  input  logic                          cpu_rst,
  input  logic                          req0_valid,
  output logic                          req0_ready,
  input  logic [rf_ctrl_pkg::REG_AW-1:0] req0_rd,
  input  logic [XLEN-1:0]               req0_data,
  input  logic                          req1_valid,
  output logic                          req1_ready,
  input  logic [rf_ctrl_pkg::REG_AW-1:0] req1_rd,
  input  logic [XLEN-1:0]               req1_data,
  input  logic                          claim_valid,
  input  logic [rf_ctrl_pkg::REG_AW-1:0] claim_rd,
  output logic                          RegWEn,
  output logic [rf_ctrl_pkg::REG_AW-1:0] rd,
  output logic [XLEN-1:0]               mux_out,
  output logic [NREG-1:0]               busy_vec,
  output logic                          claim_err
);
  localparam logic [3:0] AGE_MAX = 4'(MAX_WAIT);
  rf_ctrl_pkg::grant_e w_gnt;
  logic [rf_ctrl_pkg::REG_AW-1:0] w_rd;
  logic [XLEN-1:0] w_data;
  logic [3:0] r_age;
  logic w_xfer;
  // Requester 1 pre-empts only once it has been refused MAX_WAIT times in a row
  always_comb begin
    w_gnt = cpu_rst ? rf_ctrl_pkg::GNT_NONE
          : (req0_valid && !(req1_valid && r_age == AGE_MAX)) ? rf_ctrl_pkg::GNT_0
          : req1_valid ? rf_ctrl_pkg::GNT_1 : rf_ctrl_pkg::GNT_NONE;
    req0_ready = w_gnt == rf_ctrl_pkg::GNT_0;
    req1_ready = w_gnt == rf_ctrl_pkg::GNT_1;
    w_xfer = w_gnt != rf_ctrl_pkg::GNT_NONE;
    w_rd = req1_ready ? req1_rd : req0_rd;
    w_data = req1_ready ? req1_data : req0_data;
  end
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      RegWEn  <= 1'b0;
      rd      <= '0;
      mux_out <= '0;
      r_age   <= '0;
    end else begin
      RegWEn <= w_xfer && w_rd != '0;
      if (w_xfer) begin
        rd      <= w_rd;
        mux_out <= w_data;
      end
      r_age <= (!req1_valid || req1_ready) ? 4'd0 : (r_age == AGE_MAX) ? r_age : r_age + 4'd1;
    end
  end
  rf_scoreboard #(.NREG(NREG)) u_sb (
    .clk      (cpu_clk),
    .rst      (cpu_rst),
    .set_en   (claim_valid && claim_rd != '0),
    .set_idx  (claim_rd),
    .clr_en   (req1_ready),
    .clr_idx  (req1_rd),
    .busy_vec (busy_vec),
    .claim_err(claim_err)
  );
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed vectors checked against a spec-level model every cycle
module tb_rf_wb_arbiter;
  localparam int MAX_WAIT = 4;
  logic clk = 0, rst = 1;
  logic v0 = 0, v1 = 0, cv = 0;
  logic [4:0] rd0 = 0, rd1 = 0, crd = 0;
  logic [31:0] d0 = 0, d1 = 0;
  logic r0, r1, we, err;
  logic [4:0] rd;
  logic [31:0] mux, busy;
  int total = 0, bad = 0;
  int m_age;
  logic m_we, m_err;
  logic [4:0] m_rd;
  logic [31:0] m_data, m_busy;

  rf_wb_arbiter #(.XLEN(32), .NREG(32), .MAX_WAIT(MAX_WAIT)) dut (
    .cpu_clk(clk), .cpu_rst(rst),
    .req0_valid(v0), .req0_ready(r0), .req0_rd(rd0), .req0_data(d0),
    .req1_valid(v1), .req1_ready(r1), .req1_rd(rd1), .req1_data(d1),
    .claim_valid(cv), .claim_rd(crd),
    .RegWEn(we), .rd(rd), .mux_out(mux), .busy_vec(busy), .claim_err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // 0 = nobody, 1 = requester 0, 2 = requester 1
  function automatic int winner();
    if (rst) return 0;
    if (v0 && v1) return (m_age >= MAX_WAIT) ? 2 : 1;
    return v0 ? 1 : v1 ? 2 : 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_age <= 0; m_we <= 0; m_rd <= 0; m_data <= 0; m_busy <= 0; m_err <= 0;
    end else begin
      int g;
      logic [4:0] grd;
      logic [31:0] nb;
      logic cl;
      g = winner();
      grd = (g == 2) ? rd1 : rd0;
      m_we <= (g != 0) && (grd != 0);
      if (g != 0) begin
        m_rd <= grd;
        m_data <= (g == 2) ? d1 : d0;
      end
      m_age <= (v1 && g != 2) ? ((m_age + 1 > MAX_WAIT) ? MAX_WAIT : m_age + 1) : 0;
      nb = m_busy;
      if (g == 2) nb[rd1] = 0;
      cl = cv && crd != 0;
      m_err <= cl && m_busy[crd] && !(g == 2 && rd1 == crd);
      if (cl) nb[crd] = 1;
      nb[0] = 0;
      m_busy <= nb;
    end
  end

  always @(negedge clk) begin
    chk("req0_ready", r0, winner() == 1);
    chk("req1_ready", r1, winner() == 2);
    chk("RegWEn", we, m_we);
    chk("rd", rd, m_rd);
    chk("mux_out", mux, m_data);
    chk("busy_vec", busy, m_busy);
    chk("claim_err", err, m_err);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] seq;
    int errs;
    tick(); tick();
    rst = 0;
    // 1: async reset with a write pending, then a clean write
    v0 = 1; rd0 = 2; d0 = 32'h55;
    tick();
    chk("pre_rst_we", we, 1);
    rd0 = 5; d0 = 32'hDEADBEEF;
    #1 rst = 1;
    #1;
    chk("rst_we", we, 0);
    chk("rst_rd", rd, 0);
    chk("rst_mux", mux, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_r0", r0, 0);
    chk("rst_r1", r1, 0);
    tick();
    rst = 0;
    tick();
    chk("t1_we", we, 1);
    chk("t1_rd", rd, 5);
    chk("t1_mux", mux, 32'hDEADBEEF);
    // 2: write to x0 is accepted but not enabled
    rd0 = 0; d0 = 32'h1234;
    #1 chk("t2_ready", r0, 1);
    tick();
    chk("t2_we", we, 0);
    chk("t2_mux", mux, 32'h1234);
    v0 = 0;
    tick();
    // 3: aging hands requester 1 every fifth cycle under contention
    v0 = 1; rd0 = 10; d0 = 32'hA0;
    v1 = 1; rd1 = 11; d1 = 32'hB1;
    for (int i = 0; i < 6; i++) begin
      #1 seq[i] = r1;
      tick();
      if (i == 4) begin
        chk("t3_we", we, 1);
        chk("t3_rd", rd, 11);
        chk("t3_mux", mux, 32'hB1);
      end
    end
    chk("t3_grant_seq", {26'd0, seq}, 32'b010000);
    v0 = 0; v1 = 0;
    tick();
    // 4: claim, three cycles pending, then cleared by the writeback
    cv = 1; crd = 7;
    tick();
    cv = 0;
    chk("t4_busy_set", busy[7], 1);
    tick(); tick();
    chk("t4_busy_hold", busy[7], 1);
    v1 = 1; rd1 = 7; d1 = 32'h77;
    tick();
    v1 = 0;
    chk("t4_busy_clr", busy[7], 0);
    chk("t4_rd", rd, 7);
    // 5: re-claim in the same cycle as the clearing writeback
    cv = 1; crd = 9;
    tick();
    v1 = 1; rd1 = 9; d1 = 32'h99;
    tick();
    cv = 0; v1 = 0;
    chk("t5_busy", busy[9], 1);
    chk("t5_err", err, 0);
    v1 = 1;
    tick();
    v1 = 0;
    chk("t5_busy_clr", busy[9], 0);
    // 6: double claim pulses the error once; claim on x0 is ignored
    errs = 0;
    cv = 1; crd = 3;
    tick(); errs += err;
    tick(); errs += err;
    cv = 0;
    tick(); errs += err;
    chk("t6_err_pulses", errs, 1);
    chk("t6_busy3", busy[3], 1);
    v1 = 1; rd1 = 3; d1 = 32'h33;
    tick();
    v1 = 0;
    cv = 1; crd = 0;
    tick();
    cv = 0;
    chk("t6_x0_busy", busy, 0);
    chk("t6_x0_err", err, 0);
    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
